mem_bank_responder: RTL and testbench
=====================================

MEM_BANK_RESPONDER -- requirements
Module: mem_bank_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 17, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 17, global address width.
REQ-003 SHALL have parameter BANKS, default 2, number of banks in the system.
REQ-004 SHALL have parameter REQUESTERS, default 3, number of requesters; ID_WIDTH = max(1, $clog2(REQUESTERS)).
REQ-005 SHALL have parameter BANK_ID, default 0, index of this bank.
REQ-006 Ports SHALL be:
  clk        in   1           single clock, rising edge
  rst_n      in   1           synchronous, active-low reset
  req_valid  in   1           request present
  req_ready  out  1           request accepted when valid&&ready
  req_we     in   1           1 = write, 0 = read
  req_addr   in   ADDR_WIDTH  global address
  req_wdata  in   DATA_WIDTH  write data
  req_id     in   ID_WIDTH    requester tag
  rsp_valid  out  1           response present
  rsp_ready  in   1           response consumed when valid&&ready
  rsp_we     out  1           echo of req_we
  rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
  rsp_id     out  ID_WIDTH    echo of req_id
  rsp_err    out  1           address not owned by this bank
  n_reads    out  32          accepted good reads, wraps
  n_writes   out  32          accepted good writes, wraps
  n_errs     out  32          accepted mis-routed requests, wraps

Function
REQ-007 BANK_SIZE SHALL be ((2**ADDR_WIDTH-1)/BANKS)+1; owning bank = req_addr / BANK_SIZE; local offset = req_addr % BANK_SIZE.
REQ-008 Storage SHALL be a BANK_SIZE x DATA_WIDTH array, zero at time 0, never cleared by reset.
REQ-009 On accept of a write with owning bank == BANK_ID, word[offset] SHALL be updated at that clock edge.
REQ-010 On accept of a read with owning bank == BANK_ID, rsp_rdata SHALL carry word[offset] as of that edge, after any earlier-accepted write.
REQ-011 On accept with owning bank != BANK_ID, storage SHALL be unchanged; response has rsp_err=1, rsp_rdata=0.
REQ-012 Every accepted request SHALL produce exactly one response; responses SHALL leave in acceptance order.
REQ-013 Latency: a request accepted at edge T SHALL be visible on rsp_* from T+1 if the buffer was empty or popped at T.
REQ-014 Responses SHALL pass through a 2-entry buffer with states EMPTY, ONE, FULL.
REQ-015 req_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, independent of req_valid and rsp_ready.
REQ-016 Transitions: push only -> count+1; pop only -> count-1; push and pop in the same cycle -> count unchanged, with the head replaced in order.
REQ-017 With rsp_ready held 1, SHALL sustain one request per cycle indefinitely.
REQ-018 rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-019 Counters SHALL increment by 1 on the accept edge and wrap from 2^32-1 to 0.

Reset
REQ-020 With rst_n=0 at an edge: state SHALL become EMPTY, rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_id=0, rsp_err=0, counters=0, req_ready=1 from the next cycle.
REQ-021 Reset mid-operation SHALL drop buffered responses without emitting them; a request presented in the reset cycle SHALL NOT be accepted, and storage SHALL be retained.

Structure
REQ-022 Shared package params_pkg SHALL hold BANK_SIZE, the bank_req_t struct (we, addr, wdata, id) and the bank_rsp_t struct (we, rdata, id, err).
REQ-023 The 2-entry in-order buffer SHALL be a sub-module named rsp_fifo2.

Verification
REQ-024 BANK_ID=1: write 0x10005 data 0x1ABCD id 2 -> next cycle rsp_valid=1, we=1, id=2, err=0, rdata=0; then read 0x10005 id 0 -> rdata=0x1ABCD, n_writes=1, n_reads=1.
REQ-025 BANK_ID=1: write 0x00005 data 0x00FFF -> rsp_err=1, n_errs=1; then read 0x10005 -> unchanged value.
REQ-026 rsp_ready=0 with 3 back-to-back reads (ids 0,1,2) -> 2 accepted, req_ready=0; after rsp_ready=1 -> ids 0,1,2 in order, with id 2 accepted once space frees.
REQ-027 rsp_ready=1 with 100 alternating write/read to the same offset -> no stall cycles, each read returns the immediately preceding write data.
REQ-028 rst_n=0 while FULL -> rsp_valid=0 next cycle, counters=0; then read of a previously written word -> old data returned.

Source files
------------

// File: rtl/params_pkg.sv
// Shared definitions for the memory bank responder: default sizing,
// request/response records and the response buffer state encoding.
package params_pkg;

  localparam int DFLT_DATA_WIDTH = 17;
  localparam int DFLT_ADDR_WIDTH = 17;
  localparam int DFLT_BANKS      = 2;
  localparam int DFLT_REQUESTERS = 3;
  localparam int DFLT_ID_WIDTH   = (DFLT_REQUESTERS > 1) ? $clog2(DFLT_REQUESTERS) : 1;

  // Words per bank: the address space split evenly, rounded up.
  function automatic int calc_bank_size(input int aw, input int banks);
    longint span;
    span = (longint'(1) << aw) - longint'(1);
    return int'(span / longint'(banks)) + 1;
  endfunction

  localparam int BANK_SIZE = calc_bank_size(DFLT_ADDR_WIDTH, DFLT_BANKS);

  typedef struct packed {
    logic                       we;
    logic [DFLT_ADDR_WIDTH-1:0] addr;
    logic [DFLT_DATA_WIDTH-1:0] wdata;
    logic [DFLT_ID_WIDTH-1:0]   id;
  } bank_req_t;

  typedef struct packed {
    logic                       we;
    logic [DFLT_DATA_WIDTH-1:0] rdata;
    logic [DFLT_ID_WIDTH-1:0]   id;
    logic                       err;
  } bank_rsp_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry in-order response buffer. The head entry is a register that
// drives the response port directly, so outputs are stable while stalled.
module rsp_fifo2
  import params_pkg::*;
#(
  parameter type entry_t = bank_rsp_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  output logic   in_ready,
  input  entry_t din,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t dout
);

  fifo_state_e state_r, state_s;
  entry_t      head_r, head_s;
  entry_t      tail_r, tail_s;
  logic        pop_s;

  assign in_ready  = (state_r != FIFO_FULL);
  assign out_valid = (state_r != FIFO_EMPTY);
  assign dout      = head_r;
  assign pop_s     = out_valid && out_ready;

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FIFO_EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      state_r <= state_s;
      head_r  <= head_s;
      tail_r  <= tail_s;
    end
  end

  // Next state and entry movement; pushes while FULL are refused upstream.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case (state_r)
      FIFO_EMPTY: begin
        if (push) begin
          head_s  = din;
          state_s = FIFO_ONE;
        end else begin
          state_s = FIFO_EMPTY;
        end
      end
      FIFO_ONE: begin
        if (push && pop_s) begin
          head_s  = din;
          state_s = FIFO_ONE;
        end else if (push) begin
          tail_s  = din;
          state_s = FIFO_FULL;
        end else if (pop_s) begin
          state_s = FIFO_EMPTY;
        end else begin
          state_s = FIFO_ONE;
        end
      end
      FIFO_FULL: begin
        if (pop_s) begin
          head_s  = tail_r;
          state_s = FIFO_ONE;
        end else begin
          state_s = FIFO_FULL;
        end
      end
      default: begin
        state_s = FIFO_EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/mem_bank_responder.sv
// One bank of a banked memory: serves requests that map to BANK_ID, flags
// mis-routed ones, and returns in-order responses through rsp_fifo2.
module mem_bank_responder
  import params_pkg::*;
#(
  parameter  int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter  int ADDR_WIDTH = DFLT_ADDR_WIDTH,
  parameter  int BANKS      = DFLT_BANKS,
  parameter  int REQUESTERS = DFLT_REQUESTERS,
  parameter  int BANK_ID    = 0,
  localparam int ID_WIDTH   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic                  rsp_err,
  output logic [31:0]           n_reads,
  output logic [31:0]           n_writes,
  output logic [31:0]           n_errs
);

  localparam int BANK_WORDS = calc_bank_size(ADDR_WIDTH, BANKS);
  localparam int OFF_WIDTH  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  // One extra bit so BANK_WORDS still fits when a single bank spans everything.
  localparam logic [ADDR_WIDTH:0] SIZE_X = (ADDR_WIDTH + 1)'(BANK_WORDS);
  localparam logic [ADDR_WIDTH:0] OWN_X  = (ADDR_WIDTH + 1)'(BANK_ID);

  logic [DATA_WIDTH-1:0] mem_r [BANK_WORDS] = '{default: '0};

  bank_req_t             req_s;
  bank_rsp_t             rsp_in_s;
  bank_rsp_t             rsp_out_s;
  logic [ADDR_WIDTH:0]   addr_x_s;
  logic [OFF_WIDTH-1:0]  off_s;
  logic                  hit_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [31:0]           n_reads_r, n_writes_r, n_errs_r;

  assign req_s     = {req_we, req_addr, req_wdata, req_id};
  assign addr_x_s  = {1'b0, req_s.addr};
  assign hit_s     = ((addr_x_s / SIZE_X) == OWN_X);
  assign off_s     = OFF_WIDTH'(addr_x_s % SIZE_X);
  assign rd_word_s = mem_r[off_s];
  assign accept_s  = rst_n && req_valid && req_ready;

  // Response record for the request currently on the port.
  always_comb begin
    rsp_in_s    = '0;
    rsp_in_s.we = req_s.we;
    rsp_in_s.id = req_s.id;
    if (hit_s) begin
      rsp_in_s.err   = 1'b0;
      rsp_in_s.rdata = req_s.we ? '0 : rd_word_s;
    end else begin
      rsp_in_s.err   = 1'b1;
      rsp_in_s.rdata = '0;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (accept_s && req_s.we && hit_s) begin
      mem_r[off_s] <= req_s.wdata;
    end
  end

  // Accept counters, split by outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_reads_r  <= 32'd0;
      n_writes_r <= 32'd0;
      n_errs_r   <= 32'd0;
    end else if (accept_s) begin
      if (!hit_s) begin
        n_errs_r <= n_errs_r + 32'd1;
      end else if (req_s.we) begin
        n_writes_r <= n_writes_r + 32'd1;
      end else begin
        n_reads_r <= n_reads_r + 32'd1;
      end
    end
  end

  rsp_fifo2 #(
    .entry_t (bank_rsp_t)
  ) u_rsp_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept_s),
    .in_ready  (req_ready),
    .din       (rsp_in_s),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .dout      (rsp_out_s)
  );

  assign rsp_we    = rsp_out_s.we;
  assign rsp_rdata = rsp_out_s.rdata;
  assign rsp_id    = rsp_out_s.id;
  assign rsp_err   = rsp_out_s.err;
  assign n_reads   = n_reads_r;
  assign n_writes  = n_writes_r;
  assign n_errs    = n_errs_r;

endmodule

// File: tb/tb_mem_bank_responder.sv
// Directed bench for mem_bank_responder configured as bank 1 of 2.
module tb_mem_bank_responder;

  localparam int DW  = 17;
  localparam int AW  = 17;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [IDW-1:0] req_id;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [IDW-1:0] rsp_id;
  logic          rsp_err;
  logic [31:0]   n_reads, n_writes, n_errs;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int exp_reads = 0;
  int exp_writes = 0;
  int exp_errs = 0;
  logic [DW-1:0] last_wdata;

  always #5 clk = ~clk;

  mem_bank_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BANKS      (2),
    .REQUESTERS (3),
    .BANK_ID    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_id    (req_id),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .n_reads   (n_reads),
    .n_writes  (n_writes),
    .n_errs    (n_errs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [IDW-1:0] id);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_id    = id;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_n_reads"},  n_reads,  32'(exp_reads));
    check({tag, "_n_writes"}, n_writes, 32'(exp_writes));
    check({tag, "_n_errs"},   n_errs,   32'(exp_errs));
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 17'h0, 17'h0, 2'd0);
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_we",    32'(rsp_we),    32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check_counters("rst");
    rst_n = 1'b1;

    // Good write then read-back in bank 1
    drive(1'b1, 1'b1, 17'h10005, 17'h1ABCD, 2'd2);
    tick();
    exp_writes++;
    check("wr_valid", 32'(rsp_valid), 32'd1);
    check("wr_we",    32'(rsp_we),    32'd1);
    check("wr_id",    32'(rsp_id),    32'd2);
    check("wr_err",   32'(rsp_err),   32'd0);
    check("wr_rdata", 32'(rsp_rdata), 32'd0);
    drive(1'b1, 1'b0, 17'h10005, 17'h0, 2'd0);
    tick();
    exp_reads++;
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_we",    32'(rsp_we),    32'd0);
    check("rd_id",    32'(rsp_id),    32'd0);
    check("rd_rdata", 32'(rsp_rdata), 32'h1ABCD);
    check_counters("rd");

    // Mis-routed write must not disturb bank 1 storage
    drive(1'b1, 1'b1, 17'h00005, 17'h00FFF, 2'd1);
    tick();
    exp_errs++;
    check("mis_err",   32'(rsp_err),   32'd1);
    check("mis_rdata", 32'(rsp_rdata), 32'd0);
    check("mis_id",    32'(rsp_id),    32'd1);
    check_counters("mis");
    drive(1'b1, 1'b0, 17'h10005, 17'h0, 2'd3);
    tick();
    exp_reads++;
    check("mis_rb_rdata", 32'(rsp_rdata), 32'h1ABCD);
    check("mis_rb_err",   32'(rsp_err),   32'd0);

    // Bank boundary addresses
    drive(1'b1, 1'b1, 17'h1FFFF, 17'h15555, 2'd1);
    tick();
    exp_writes++;
    check("top_wr_err", 32'(rsp_err), 32'd0);
    drive(1'b1, 1'b1, 17'h10000, 17'h0A5A5, 2'd2);
    tick();
    exp_writes++;
    drive(1'b1, 1'b0, 17'h1FFFF, 17'h0, 2'd0);
    tick();
    exp_reads++;
    check("top_rd_rdata", 32'(rsp_rdata), 32'h15555);
    drive(1'b1, 1'b0, 17'h10000, 17'h0, 2'd1);
    tick();
    exp_reads++;
    check("base_rd_rdata", 32'(rsp_rdata), 32'h0A5A5);
    drive(1'b1, 1'b0, 17'h0FFFF, 17'h0, 2'd2);
    tick();
    exp_errs++;
    check("below_err",   32'(rsp_err),   32'd1);
    check("below_rdata", 32'(rsp_rdata), 32'd0);
    drive(1'b0, 1'b0, 17'h0, 17'h0, 2'd0);
    tick();
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check_counters("bnd");

    // Backpressure: three back-to-back reads into a 2-deep buffer
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 17'h10005, 17'h0, 2'd0);
    tick();
    exp_reads++;
    check("bp0_valid", 32'(rsp_valid), 32'd1);
    check("bp0_id",    32'(rsp_id),    32'd0);
    check("bp0_ready", 32'(req_ready), 32'd1);
    drive(1'b1, 1'b0, 17'h1FFFF, 17'h0, 2'd1);
    tick();
    exp_reads++;
    check("bp1_ready", 32'(req_ready), 32'd0);
    check("bp1_id",    32'(rsp_id),    32'd0);
    drive(1'b1, 1'b0, 17'h10000, 17'h0, 2'd2);
    tick();
    check("bp2_ready", 32'(req_ready), 32'd0);
    check("bp2_hold_id",    32'(rsp_id),    32'd0);
    check("bp2_hold_rdata", 32'(rsp_rdata), 32'h1ABCD);
    check_counters("bp2");
    rsp_ready = 1'b1;
    tick();
    check("bp3_id",    32'(rsp_id),    32'd1);
    check("bp3_rdata", 32'(rsp_rdata), 32'h15555);
    check("bp3_ready", 32'(req_ready), 32'd1);
    check_counters("bp3");
    tick();
    exp_reads++;
    check("bp4_valid", 32'(rsp_valid), 32'd1);
    check("bp4_id",    32'(rsp_id),    32'd2);
    check("bp4_rdata", 32'(rsp_rdata), 32'h0A5A5);
    drive(1'b0, 1'b0, 17'h0, 17'h0, 2'd0);
    tick();
    check("bp5_valid", 32'(rsp_valid), 32'd0);
    check_counters("bp5");

    // Streaming alternating write/read to one offset at full rate
    last_wdata = '0;
    for (int i = 0; i < 100; i++) begin
      check("st_ready_pre", 32'(req_ready), 32'd1);
      if (i % 2 == 0) begin
        last_wdata = DW'(i * 1153 + 5);
        drive(1'b1, 1'b1, 17'h10100, last_wdata, IDW'(i % 3));
        tick();
        exp_writes++;
        check("st_wr_we", 32'(rsp_we), 32'd1);
      end else begin
        drive(1'b1, 1'b0, 17'h10100, 17'h0, IDW'(i % 3));
        tick();
        exp_reads++;
        check("st_rd_rdata", 32'(rsp_rdata), 32'(last_wdata));
      end
      check("st_valid", 32'(rsp_valid), 32'd1);
      check("st_id",    32'(rsp_id),    32'(i % 3));
    end
    drive(1'b0, 1'b0, 17'h0, 17'h0, 2'd0);
    tick();
    check_counters("st");

    // Reset while FULL drops responses and keeps storage
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 17'h10000, 17'h0, 2'd1);
    tick();
    drive(1'b1, 1'b0, 17'h10005, 17'h0, 2'd2);
    tick();
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 17'h10005, 17'h0, 2'd3);
    tick();
    exp_reads = 0;
    exp_writes = 0;
    exp_errs = 0;
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd1);
    check("mrst_id",    32'(rsp_id),    32'd0);
    check_counters("mrst");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 17'h0, 17'h0, 2'd0);
    tick();
    check("post_valid", 32'(rsp_valid), 32'd0);
    check_counters("post");
    drive(1'b1, 1'b0, 17'h10005, 17'h0, 2'd1);
    tick();
    exp_reads++;
    check("keep_rdata", 32'(rsp_rdata), 32'h1ABCD);
    check("keep_id",    32'(rsp_id),    32'd1);
    drive(1'b1, 1'b0, 17'h10100, 17'h0, 2'd2);
    tick();
    exp_reads++;
    check("keep2_rdata", 32'(rsp_rdata), 32'(last_wdata));
    drive(1'b0, 1'b0, 17'h0, 17'h0, 2'd0);
    tick();
    check_counters("end");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
